// File: rtl/tile_fb_scaler.sv
// Tile-grid framebuffer reader: maps VGA positions onto a scaled tile
// array and aligns sync/pixel data to the pixel RAM read latency.
module tile_fb_scaler #(
  parameter int AW = 8,
  parameter int DW = 3,
  parameter int SCALE = 64,
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int ORIGIN_X = 0,
  parameter int ORIGIN_Y = 0,
  parameter int RD_LAT = 1,
  parameter logic [DW-1:0] BORDER = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   pos_x,
  input  logic [11:0]   pos_y,
  input  logic          de_in,
  input  logic          hsync_n_in,
  input  logic          vsync_n_in,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] pixel_out,
  output logic          hsync_n_out,
  output logic          vsync_n_out,
  output logic          frame_start
);

  localparam int L = RD_LAT + 2;
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SW-1:0] SMAX = SW'(SCALE - 1);
  localparam logic [AW-1:0] CMAX = AW'(GRID_W - 1);
  localparam logic [AW-1:0] RMAX = AW'(GRID_H - 1);
  localparam logic [AW-1:0] GWA = AW'(GRID_W);
  localparam logic [12:0] X0 = 13'(ORIGIN_X);
  localparam logic [12:0] X1 = 13'(ORIGIN_X + GRID_W * SCALE);
  localparam logic [12:0] Y0 = 13'(ORIGIN_Y);
  localparam logic [12:0] Y1 = 13'(ORIGIN_Y + GRID_H * SCALE);
  // delay-line word: {hsync, vsync, de, in_grid, frame flag}
  localparam logic [4:0] IDLE = 5'b11000;

  typedef enum logic {UNSYNC, SYNC} state_t;

  state_t state;
  logic vs_q;
  logic de_q;
  logic ln_ok;
  logic armed;
  logic [SW-1:0] sub_x;
  logic [SW-1:0] sub_y;
  logic [AW-1:0] col;
  logic [AW-1:0] row;
  logic [AW-1:0] row_base;
  logic [L-2:0][4:0] dl;

  logic sync_ok;
  logic x_in;
  logic y_in;
  logic in_grid;
  logic x_clr;
  logic vs_fall;
  logic de_fall;
  logic fs_flag;
  logic [SW-1:0] cur_sub;
  logic [AW-1:0] cur_col;

  assign sync_ok = (state == SYNC);
  assign x_in = ({1'b0, pos_x} >= X0) && ({1'b0, pos_x} < X1);
  assign y_in = ({1'b0, pos_y} >= Y0) && ({1'b0, pos_y} < Y1);
  assign in_grid = sync_ok & de_in & x_in & y_in;
  assign x_clr = de_in && ({1'b0, pos_x} == X0);
  assign vs_fall = vs_q & ~vsync_n_in;
  assign de_fall = de_q & ~de_in;
  assign fs_flag = sync_ok & armed & de_in;
  // the origin pixel addresses column 0 in the same cycle it clears
  assign cur_sub = x_clr ? '0 : sub_x;
  assign cur_col = x_clr ? '0 : col;

  // sync state: locks on the first vsync falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= UNSYNC;
    else if (vs_fall) state <= SYNC;
  end

  // edge detectors, line-qualify flag and frame-start arming
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q <= 1'b1;
      de_q <= 1'b0;
      ln_ok <= 1'b0;
      armed <= 1'b0;
    end else begin
      vs_q <= vsync_n_in;
      de_q <= de_in;
      if (de_in) ln_ok <= ({1'b0, pos_y} >= Y0);
      if (vs_fall) armed <= 1'b1;
      else if (fs_flag) armed <= 1'b0;
    end
  end

  // horizontal tile counters, col saturates at the last tile
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_x <= '0;
      col <= '0;
    end else if (in_grid) begin
      if (cur_sub == SMAX) begin
        sub_x <= '0;
        col <= (cur_col == CMAX) ? CMAX : cur_col + 1'b1;
      end else begin
        sub_x <= cur_sub + 1'b1;
        col <= cur_col;
      end
    end else if (x_clr) begin
      sub_x <= '0;
      col <= '0;
    end
  end

  // vertical tile counters, vsync clear beats the line advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_y <= '0;
      row <= '0;
      row_base <= '0;
    end else if (vs_fall) begin
      sub_y <= '0;
      row <= '0;
      row_base <= '0;
    end else if (de_fall && ln_ok) begin
      if (sub_y == SMAX) begin
        sub_y <= '0;
        if (row != RMAX) begin
          row <= row + 1'b1;
          row_base <= row_base + GWA;
        end
      end else begin
        sub_y <= sub_y + 1'b1;
      end
    end
  end

  // RAM address, held across pixels outside the grid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_addr <= '0;
    else if (in_grid) mem_addr <= row_base + cur_col;
  end

  // control delay line matching the RAM read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dl <= {(L-1){IDLE}};
    else dl <= {dl[L-3:0], {hsync_n_in, vsync_n_in, de_in & sync_ok, in_grid, fs_flag}};
  end

  // output stage: blank, RAM pixel or border colour
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_out <= '0;
      hsync_n_out <= 1'b1;
      vsync_n_out <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hsync_n_out <= dl[L-2][4];
      vsync_n_out <= dl[L-2][3];
      frame_start <= dl[L-2][0];
      if (!dl[L-2][2]) pixel_out <= '0;
      else if (dl[L-2][1]) pixel_out <= mem_data;
      else pixel_out <= BORDER;
    end
  end

endmodule

// File: tb/tb_tile_fb_scaler.sv
// Scoreboard bench for tile_fb_scaler: small grid at RD_LAT 1 and 3,
// plus the default 16x12 / SCALE 64 configuration on one stimulus.
module tb_tile_fb_scaler;

  typedef struct packed {
    logic [2:0] pix;
    logic hs;
    logic vs;
    logic fs;
  } exp_t;

  localparam exp_t IDLE = exp_t'(6'b000110);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] pos_x = '0;
  logic [11:0] pos_y = '0;
  logic de_in = 1'b0;
  logic hs_in = 1'b1;
  logic vs_in = 1'b1;

  logic [2:0] ma_a, ma_b, md_a, md_b, md_c, rb1, rb2;
  logic [7:0] ma_c;
  logic [2:0] px_a, px_b, px_c;
  logic hso_a, hso_b, hso_c, vso_a, vso_b, vso_c, fs_a, fs_b, fs_c;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int fs_cnt_a = 0;
  int fs_cnt_b = 0;
  int fs_cyc_a = 0;
  int fs_cyc_b = 0;
  bit m_sync, m_armed, m_pvs;
  int ea, ec;
  exp_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;

  tile_fb_scaler #(.AW(3), .SCALE(4), .GRID_W(3), .GRID_H(2),
    .ORIGIN_X(2), .ORIGIN_Y(1), .RD_LAT(1), .BORDER(3'b111)) dut_a (
    .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .de_in(de_in),
    .hsync_n_in(hs_in), .vsync_n_in(vs_in), .mem_addr(ma_a),
    .mem_data(md_a), .pixel_out(px_a), .hsync_n_out(hso_a),
    .vsync_n_out(vso_a), .frame_start(fs_a));

  tile_fb_scaler #(.AW(3), .SCALE(4), .GRID_W(3), .GRID_H(2),
    .ORIGIN_X(2), .ORIGIN_Y(1), .RD_LAT(3), .BORDER(3'b111)) dut_b (
    .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .de_in(de_in),
    .hsync_n_in(hs_in), .vsync_n_in(vs_in), .mem_addr(ma_b),
    .mem_data(md_b), .pixel_out(px_b), .hsync_n_out(hso_b),
    .vsync_n_out(vso_b), .frame_start(fs_b));

  tile_fb_scaler dut_c (
    .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .de_in(de_in),
    .hsync_n_in(hs_in), .vsync_n_in(vs_in), .mem_addr(ma_c),
    .mem_data(md_c), .pixel_out(px_c), .hsync_n_out(hso_c),
    .vsync_n_out(vso_c), .frame_start(fs_c));

  // RAM[a] = a mod 8, one-cycle and three-cycle read ports
  always_ff @(posedge clk) begin
    md_a <= ma_a;
    md_c <= ma_c[2:0];
    rb1 <= ma_b;
    rb2 <= rb1;
    md_b <= rb2;
  end

  function automatic bit ins(int x, int y, int s, int gw, int gh, int ox, int oy);
    return x >= ox && x < ox + gw * s && y >= oy && y < oy + gh * s;
  endfunction

  function automatic int adr(int x, int y, int s, int gw, int ox, int oy);
    return ((y - oy) / s) * gw + (x - ox) / s;
  endfunction

  task automatic sb_reset();
    qa.delete();
    qb.delete();
    qc.delete();
    repeat (3) qa.push_back(IDLE);
    repeat (5) qb.push_back(IDLE);
    repeat (3) qc.push_back(IDLE);
    ea = 0;
    ec = 0;
    m_sync = 0;
    m_armed = 0;
    m_pvs = 1;
  endtask

  task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs);
    exp_t e;
    logic [5:0] got;
    bit vf, fs, is_s, is_c;
    int a;
    @(negedge clk);
    cyc_n++;
    if (qa.size() == 3) begin
      e = qa.pop_front();
      got = {px_a, hso_a, vso_a, fs_a};
      n_cmp++;
      if (got !== 6'(e)) begin
        n_bad++;
        $display("FAIL out_a cyc %0d: got %b want %b", cyc_n, got, 6'(e));
      end
    end
    if (qb.size() == 5) begin
      e = qb.pop_front();
      got = {px_b, hso_b, vso_b, fs_b};
      n_cmp++;
      if (got !== 6'(e)) begin
        n_bad++;
        $display("FAIL out_b cyc %0d: got %b want %b", cyc_n, got, 6'(e));
      end
    end
    if (qc.size() == 3) begin
      e = qc.pop_front();
      got = {px_c, hso_c, vso_c, fs_c};
      n_cmp++;
      if (got !== 6'(e)) begin
        n_bad++;
        $display("FAIL out_c cyc %0d: got %b want %b", cyc_n, got, 6'(e));
      end
    end
    n_cmp++;
    if (ma_a !== 3'(ea) || ma_b !== 3'(ea) || ma_c !== 8'(ec)) begin
      n_bad++;
      $display("FAIL addr cyc %0d: got %0d/%0d/%0d want %0d/%0d/%0d",
               cyc_n, ma_a, ma_b, ma_c, ea, ea, ec);
    end
    if (fs_a) begin fs_cnt_a++; fs_cyc_a = cyc_n; end
    if (fs_b) begin fs_cnt_b++; fs_cyc_b = cyc_n; end
    pos_x = 12'(x);
    pos_y = 12'(y);
    de_in = de;
    hs_in = hs;
    vs_in = vs;
    vf = m_pvs && !vs;
    fs = m_sync && m_armed && de;
    is_s = m_sync && de && ins(x, y, 4, 3, 2, 2, 1);
    is_c = m_sync && de && ins(x, y, 64, 16, 12, 0, 0);
    e.hs = hs;
    e.vs = vs;
    e.fs = fs;
    if (is_s) begin
      a = adr(x, y, 4, 3, 2, 1);
      ea = a;
    end
    e.pix = !(de && m_sync) ? 3'd0 : is_s ? 3'(a % 8) : 3'b111;
    qa.push_back(e);
    qb.push_back(e);
    if (is_c) begin
      a = adr(x, y, 64, 16, 0, 0);
      ec = a;
    end
    e.pix = (is_c) ? 3'(a % 8) : 3'd0;
    qc.push_back(e);
    if (vf) begin
      m_sync = 1;
      m_armed = 1;
    end else if (fs) begin
      m_armed = 0;
    end
    m_pvs = vs;
  endtask

  task automatic line(input int y, input int nact, input bit vs, input bit act);
    for (int x = 0; x < nact + 4; x++)
      step(x, y, act && x < nact, !(x == nact + 1 || x == nact + 2), vs);
  endtask

  task automatic frame(input int nact, input int nlines);
    line(nlines + 1, nact, 1'b0, 1'b0);
    for (int y = 0; y < nlines; y++) line(y, nact, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    logic [8:0] got;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {px_a, hso_a, vso_a, fs_a, ma_a};
    n_cmp++;
    if (got !== 9'b000_110_000) begin
      n_bad++;
      $display("FAIL reset_a: got %b want %b", got, 9'b000_110_000);
    end
    got = {px_b, hso_b, vso_b, fs_b, ma_b};
    n_cmp++;
    if (got !== 9'b000_110_000) begin
      n_bad++;
      $display("FAIL reset_b: got %b want %b", got, 9'b000_110_000);
    end
    n_cmp++;
    if ({px_c, hso_c, vso_c, fs_c, ma_c} !== 14'b000_110_00000000) begin
      n_bad++;
      $display("FAIL reset_c: got %b want %b",
               {px_c, hso_c, vso_c, fs_c, ma_c}, 14'b000_110_00000000);
    end
    @(negedge clk);
    rst = 1'b1;
    sb_reset();
    fs_cnt_a = 0;
    for (int y = 0; y < 3; y++) line(y, 16, 1'b1, 1'b1);
    n_cmp++;
    if (fs_cnt_a !== 0) begin
      n_bad++;
      $display("FAIL unsync_fs: got %0d want 0", fs_cnt_a);
    end
  endtask

  task automatic test_sweep();
    int px[8] = '{7, 2, 5, 6, 13, 1, 14, 5};
    int py[8] = '{5, 1, 1, 1, 8, 3, 3, 9};
    int pa[8] = '{4, 0, 0, 1, 5, 2, 2, 5};
    fs_cnt_a = 0;
    fs_cnt_b = 0;
    line(12, 16, 1'b0, 1'b0);
    for (int y = 0; y < 10; y++) begin
      for (int x = 0; x < 20; x++) begin
        step(x, y, x < 16, !(x == 17 || x == 18), 1'b1);
        for (int i = 0; i < 8; i++) begin
          if (px[i] == x && py[i] == y) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (ma_a !== 3'(pa[i])) begin
              n_bad++;
              $display("FAIL probe (%0d,%0d): got %0d want %0d", x, y, ma_a, pa[i]);
            end
          end
        end
      end
    end
    n_cmp++;
    if (fs_cnt_a !== 1 || fs_cnt_b !== 1) begin
      n_bad++;
      $display("FAIL sweep_fs: got %0d/%0d want 1/1", fs_cnt_a, fs_cnt_b);
    end
  endtask

  task automatic test_border();
    frame(24, 12);
    n_cmp++;
    if (ma_a !== 3'd5 || ma_b !== 3'd5) begin
      n_bad++;
      $display("FAIL border_addr: got %0d/%0d want 5/5", ma_a, ma_b);
    end
  endtask

  task automatic test_midreset();
    line(12, 16, 1'b0, 1'b0);
    for (int y = 0; y < 4; y++) line(y, 16, 1'b1, 1'b1);
    for (int x = 0; x <= 8; x++) step(x, 4, 1'b1, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({px_a, hso_a, vso_a, fs_a, ma_a} !== 9'b000_110_000) begin
      n_bad++;
      $display("FAIL midreset_a: got %b want %b",
               {px_a, hso_a, vso_a, fs_a, ma_a}, 9'b000_110_000);
    end
    n_cmp++;
    if ({px_b, hso_b, vso_b, fs_b, ma_b} !== 9'b000_110_000) begin
      n_bad++;
      $display("FAIL midreset_b: got %b want %b",
               {px_b, hso_b, vso_b, fs_b, ma_b}, 9'b000_110_000);
    end
    @(negedge clk);
    rst = 1'b1;
    sb_reset();
    fs_cnt_a = 0;
    for (int x = 9; x < 20; x++) step(x, 4, x < 16, !(x == 17 || x == 18), 1'b1);
    for (int y = 5; y < 10; y++) line(y, 16, 1'b1, 1'b1);
    n_cmp++;
    if (fs_cnt_a !== 0) begin
      n_bad++;
      $display("FAIL midreset_fs0: got %0d want 0", fs_cnt_a);
    end
    frame(16, 10);
    n_cmp++;
    if (fs_cnt_a !== 1) begin
      n_bad++;
      $display("FAIL midreset_fs1: got %0d want 1", fs_cnt_a);
    end
  endtask

  task automatic test_defaults();
    int n;
    for (int x = 0; x < 4; x++) step(x, 800, 1'b0, 1'b1, 1'b0);
    for (int y = 0; y < 768; y++) begin
      n = (y == 70 || y == 767) ? 1024 : 4;
      for (int x = 0; x < n + 2; x++) begin
        step(x, y, x < n, x != n, 1'b1);
        if ((x == 130 && y == 70) || (x == 1023 && y == 767)) begin
          @(posedge clk);
          #1;
          n_cmp++;
          if (ma_c !== ((y == 70) ? 8'd18 : 8'd191)) begin
            n_bad++;
            $display("FAIL default (%0d,%0d): got %0d want %0d",
                     x, y, ma_c, (y == 70) ? 18 : 191);
          end
        end
      end
    end
  endtask

  task automatic test_lat3();
    int k0;
    fs_cyc_a = -1;
    fs_cyc_b = -1;
    line(12, 16, 1'b0, 1'b0);
    step(0, 0, 1'b1, 1'b1, 1'b1);
    k0 = cyc_n;
    for (int x = 1; x < 20; x++) step(x, 0, x < 16, !(x == 17 || x == 18), 1'b1);
    for (int y = 1; y < 10; y++) line(y, 16, 1'b1, 1'b1);
    n_cmp++;
    if (fs_cyc_b - k0 !== 5) begin
      n_bad++;
      $display("FAIL lat3_fs: got %0d want 5", fs_cyc_b - k0);
    end
    n_cmp++;
    if (fs_cyc_a - k0 !== 3) begin
      n_bad++;
      $display("FAIL lat1_fs: got %0d want 3", fs_cyc_a - k0);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_border();
    test_midreset();
    test_defaults();
    test_lat3();
    repeat (6) step(0, 0, 1'b0, 1'b1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_fb_scaler.md
# tile_fb_scaler

Parametrised tile-grid framebuffer reader between the 1024x768 VGA timing driver and the dual-port pixel RAM. It maps each active VGA position onto a GRID_W x GRID_H tile array, with each tile SCALE x SCALE pixels, placed at a configurable origin. Addresses come from counters, with no dividers or multipliers. The block aligns sync and pixel data to the RAM read latency and drives BORDER colour outside the grid instead of wrapping to tile 0.

## Interface
Parameters:
- AW, 8: RAM address width. GRID_W*GRID_H must be ≤ 2^AW.
- DW, 3: pixel width (RGB111).
- SCALE, 64: tile edge in screen pixels. Any integer ≥ 1.
- GRID_W, 16: tiles per row.
- GRID_H, 12: tile rows.
- ORIGIN_X, 0: first screen column of the grid.
- ORIGIN_Y, 0: first screen row of the grid.
- RD_LAT, 1: RAM read latency in cycles, ≥ 1.
- BORDER, 3'b000: colour for active pixels outside the grid.

Ports:
- clk  in  1  pixel clock (75 MHz).
- rst  in  1  asynchronous, active-low reset.
- pos_x  in  12  column of the current pixel.
- pos_y  in  12  row of the current pixel.
- de_in  in  1  active-video flag for the current pixel.
- hsync_n_in  in  1  horizontal sync from the driver.
- vsync_n_in  in  1  vertical sync from the driver.
- mem_addr  out  AW  RAM read address.
- mem_data  in  DW  RAM read data, valid RD_LAT cycles after mem_addr.
- pixel_out  out  DW  pixel to the port.
- hsync_n_out  out  1  delayed horizontal sync.
- vsync_n_out  out  1  delayed vertical sync.
- frame_start  out  1  one-cycle pulse with the first active pixel of a frame.

## Operation
- Inside region: ORIGIN_X ≤ x < ORIGIN_X+GRID_W*SCALE and ORIGIN_Y ≤ y < ORIGIN_Y+GRID_H*SCALE.
- For inside pixels: mem_addr = ((y-ORIGIN_Y)/SCALE)*GRID_W + (x-ORIGIN_X)/SCALE.
- X counters: sub_x runs 0..SCALE-1 and col runs 0..GRID_W-1.
  - Both clear when de_in=1 and pos_x==ORIGIN_X.
  - Both advance on every inside pixel; col increments when sub_x wraps.
- Y counters: sub_y, row, and row_base (= row*GRID_W, updated by adding GRID_W).
  - All clear on the vsync_n_in falling edge.
  - All advance on each de_in falling edge whose line had pos_y ≥ ORIGIN_Y.
- Address: mem_addr = row_base + col.
  - Holds its last value for non-inside pixels.
  - Never exceeds GRID_W*GRID_H-1.
- Sync state machine:
  - States: UNSYNC and SYNC.
  - Reset enters UNSYNC.
  - UNSYNC → SYNC on the first vsync_n_in falling edge.
  - SYNC has no exit except reset.
  - In UNSYNC, inside is forced 0 and pixel_out is 0 for all pixels.
- Output selection, after the delay line:
  - de=0: pixel_out = 0.
  - de=1 and inside=1: pixel_out = mem_data.
  - de=1 and inside=0: pixel_out = BORDER.
- frame_start pulses with the first de=1 pixel after a vsync falling edge, only in SYNC.
- Reset values:
  - mem_addr = 0, pixel_out = 0, frame_start = 0.
  - hsync_n_out = 1, vsync_n_out = 1.
  - Delay lines fill with the idle pattern: sync = 1, de = 0, inside = 0.

## Timing
- Total latency L = RD_LAT + 2 cycles from a pos_x/pos_y/de_in/sync sample to its pixel_out, hsync_n_out and vsync_n_out.
- Pipeline:
  - Cycle t: the block samples inputs.
  - Edge t+1: mem_addr is registered.
  - RAM returns mem_data at t+1+RD_LAT.
  - pixel_out is registered at t+2+RD_LAT.
- hsync, vsync, de, inside and the frame_start flag pass through an L-stage shift register, so all outputs change on the same edge.
- Tile-boundary events:
  - col changes on the edge after the pixel with sub_x==SCALE-1.
  - The first pixel of a new tile addresses the new col; there is no one-pixel lag.
- Simultaneous events:
  - If a de_in falling edge and a vsync_n_in falling edge occur in the same cycle, the vsync clear wins.
- Overflow and wrap:
  - A line longer than the grid: col saturates at GRID_W-1, and pixels past the grid show BORDER.
  - Lines past row GRID_H-1 show BORDER; row does not wrap to 0.
- Reset mid-frame:
  - All outputs return to reset values asynchronously.
  - After release, pixel_out stays 0 until the next vsync_n_in falling edge.

## Test plan
Bench configuration: SCALE=4, GRID_W=3, GRID_H=2, ORIGIN_X=2, ORIGIN_Y=1, RD_LAT=1, RAM[a]=a mod 8.
- Full frame sweep, pixel (x=7, y=5) -> mem_addr=4; pixel_out=3'b100 exactly 3 cycles after the sample; sync delayed 3 cycles.
- Pixels (2,1), (5,1) and (6,1) -> addresses 0, 0 and 1; (13,8) -> 5.
- Pixels (14,3), (1,3) and (5,9) -> pixel_out=BORDER; mem_addr unchanged from the previous inside pixel.
- Reset asserted mid-line at (8,4) -> outputs go to idle immediately; after release, pixel_out=0 through the remainder of the frame; the next frame renders normally and frame_start pulses once.
- Default parameters (SCALE=64, 16x12) -> (130,70) addresses 18; (1023,767) addresses 191; no BORDER pixels in the full frame.
- RD_LAT=3 -> pixel, sync and frame_start latency all 5 cycles; pixel data matches the addresses from the other scenarios.
